instr_decode_queue: RTL and testbench
=====================================

// Module: instr_decode_queue
// PURPOSE
//  Registered, parametrised next-generation decoder: decodes 32-bit instrs (groups 0-6, PkgInstrDecoder
//  formats) into PortOut_InstrDecoder fields plus PC, buffers them in a DEPTH-entry FIFO with
//  valid/ready handshakes, and interlocks issue behind stalling instrs until the EX unit signals done.
//  Sits between fetch and the register-read/execute stage of the Frost32 pipeline.
// PARAMETERS
//  DEPTH      2   decoded-entry FIFO depth; power of 2, >=2
//  IMM_WIDTH  16  width of out_imm; >=16; all immediates sign-extended to it
//  PC_WIDTH   32  width of in_pc/out_pc
// PORTS
//  clk             in   1          clock
//  reset           in   1          synchronous, active-high reset
//  flush           in   1          discard all queued entries and interlock
//  in_valid        in   1          fetch presents instr
//  in_ready        out  1          queue can accept (= !full && !flush)
//  in_instr        in   32         raw instruction
//  in_pc           in   PC_WIDTH   instruction address
//  out_valid       out  1          head entry issuable
//  out_ready       in   1          downstream accepts head
//  out_dec         out  struct     PkgInstrDecoder::PortOut_InstrDecoder of head (imm_val widened)
//  out_imm         out  IMM_WIDTH  sign-extended immediate of head
//  out_pc          out  PC_WIDTH   PC of head
//  stall_done      in   1          EX pulse: outstanding stalling op complete
//  interlocked     out  1          waiting for stall_done
//  count           out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset/flush: FIFO empty, count=0, interlocked=0, out_valid=0, out_dec=0, out_imm=0, out_pc=0.
//  - Flush beats simultaneous push and pop; in_ready=0 during flush cycle.
//  - Push on in_valid&&in_ready: decode combinationally, write entry at tail. Latency: accepted in
//    cycle N -> visible at head (out_valid) in N+1 at earliest. No combinational in->out path.
//  - in_ready = !full: a full queue does not accept even if popping the same cycle.
//  - out_valid = !empty && !interlocked. Pop on out_valid&&out_ready; head outputs held stable while
//    out_valid&&!out_ready.
//  - Push and pop in the same cycle (not full): count unchanged; pointers wrap modulo DEPTH.
//  - Decode per group: 0 three-reg (stall on Mul/Udiv/Sdiv_ThreeRegs); 1 imm16 (stall on
//    Muli_TwoRegsOneImm); 2 branch, condition_type=opcode, stall if opcode<Bad2_Iog2; 3/4 jump/call,
//    condition_type=opcode, stall if opcode<Bad0_Iog3; 5 ld/st, imm12 sign-extended to IMM_WIDTH,
//    ldst_type=opcode LSBs, always stall; 6 misc, stall on Cpy_OneIretaOneReg, Cpy_OneIdstaOneReg,
//    Reti_NoArgs, Ei_NoArgs, Di_NoArgs. Unused fields are 0.
//  - Interlock FSM: IDLE -> WAIT when a head with causes_stall=1 pops; WAIT -> IDLE on stall_done.
//    stall_done in IDLE ignored. stall_done in the same cycle as a stalling pop: WAIT wins.
//    Queue keeps accepting pushes while in WAIT.
//  - Reset mid-operation: all state cleared next edge, no partial entries survive.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined: groups 7-15 and Bad* opcodes decode with extra out_illegal=1
//    bit (port present), fields zeroed, causes_stall=1 so the trap handler serialises.
//  Not defined: invalid groups decode as all-zero NOP (add zero,zero,zero), causes_stall=0; no port.
// TESTING
//  1 reset held 2 cycles, in_valid=1 -> in_ready=0, out_valid=0, count=0; release -> in_ready=1.
//  2 push add r1,r2,r3 @pc 0x100, out_ready=1 -> next cycle out_valid=1, ra=1 rb=2 rc=3, out_pc=0x100.
//  3 out_ready=0, push 3 instrs, DEPTH=2 -> in_ready=0 after 2, count=2; order kept on drain.
//  4 pop group-5 load imm12=0xFFF -> out_imm=0xFFFF, interlocked=1, out_valid=0 until stall_done,
//    then next entry issues following cycle.
//  5 flush with count=2, interlocked=1, in_valid=1 -> next cycle count=0, interlocked=0, nothing pushed.
//  6 group 0xF instr -> macro off: out_dec all 0, causes_stall=0; on: out_illegal=1, causes_stall=1.

Source files
------------

// File: rtl/instr_decode_queue_if.sv
//------------------------------------------------------------------------------
// Module      : instr_decode_queue_if (plus package PkgInstrDecoder)
// Description : Decoded-instruction record type and the fetch/issue handshake
//               bundle used by instr_decode_queue.
//               Optional macro: DECODE_ILLEGAL_TRAP_EN adds out_illegal.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package PkgInstrDecoder;
    // Opcode values that matter for stall / legality decisions
    localparam logic [3:0] c_g0_mul         = 4'd4;   // Mul_ThreeRegs
    localparam logic [3:0] c_g0_udiv        = 4'd5;   // Udiv_ThreeRegs
    localparam logic [3:0] c_g0_sdiv        = 4'd6;   // Sdiv_ThreeRegs
    localparam logic [3:0] c_g0_bad0        = 4'd14;  // first illegal three-reg op
    localparam logic [3:0] c_g1_muli        = 4'd4;   // Muli_TwoRegsOneImm
    localparam logic [3:0] c_g1_bad0        = 4'd14;  // first illegal imm16 op
    localparam logic [3:0] c_g2_bad2        = 4'd13;  // Bad2_Iog2: first illegal branch op
    localparam logic [3:0] c_g3_bad0        = 4'd13;  // Bad0_Iog3: first illegal jump/call op
    localparam logic [3:0] c_g5_bad0        = 4'd8;   // first illegal ld/st op
    localparam logic [3:0] c_g6_cpy_ireta   = 4'd1;   // Cpy_OneIretaOneReg
    localparam logic [3:0] c_g6_cpy_idsta   = 4'd3;   // Cpy_OneIdstaOneReg
    localparam logic [3:0] c_g6_reti        = 4'd4;   // Reti_NoArgs
    localparam logic [3:0] c_g6_ei          = 4'd5;   // Ei_NoArgs
    localparam logic [3:0] c_g6_di          = 4'd6;   // Di_NoArgs
    localparam logic [3:0] c_g6_bad0        = 4'd7;   // first illegal misc op

    typedef struct packed {
        logic [3:0]  group;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [3:0]  opcode;
        logic [15:0] imm_val;
        logic [3:0]  condition_type;
        logic [2:0]  ldst_type;
        logic        causes_stall;
    } PortOut_InstrDecoder;
endpackage

interface instr_decode_queue_if #(
    parameter int DEPTH     = 2,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
);
    import PkgInstrDecoder::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_instr;
    logic [PC_WIDTH-1:0]          in_pc;
    logic                         out_valid;
    logic                         out_ready;
    PortOut_InstrDecoder          out_dec;
    logic [IMM_WIDTH-1:0]         out_imm;
    logic [PC_WIDTH-1:0]          out_pc;
    logic                         stall_done;
    logic                         interlocked;
    logic [CNT_W-1:0]             count;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                         out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready, stall_done,
        input  in_ready, out_valid, out_dec, out_imm, out_pc, interlocked, count, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready, stall_done,
        output in_ready, out_valid, out_dec, out_imm, out_pc, interlocked, count, out_illegal
    );
`else
    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready, stall_done,
        input  in_ready, out_valid, out_dec, out_imm, out_pc, interlocked, count
    );
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready, stall_done,
        output in_ready, out_valid, out_dec, out_imm, out_pc, interlocked, count
    );
`endif
endinterface

`default_nettype wire

// File: rtl/instr_decode_queue.sv
//------------------------------------------------------------------------------
// Module      : instr_decode_queue
// Description : Decodes 32-bit Frost32 instructions, buffers decoded entries in
//               a DEPTH-deep FIFO and holds issue after a stalling instruction
//               until the execute unit reports completion.
//               Optional macro: DECODE_ILLEGAL_TRAP_EN (illegal-op trap decode).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_decode_queue #(
    parameter int DEPTH     = 2,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    instr_decode_queue_if.slave bus
);
    import PkgInstrDecoder::*;

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Decoder outputs
    PortOut_InstrDecoder   w_dec;
    logic [IMM_WIDTH-1:0]  w_imm;
    logic [3:0]            w_grp;
    logic [3:0]            w_op_lo;
    logic [3:0]            w_op_mid;
    logic [3:0]            w_op_ls;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                  w_bad;
    logic                  w_illegal;
    logic                  r_ill_mem [DEPTH];
`endif

    // Queue storage and control
    PortOut_InstrDecoder   r_dec_mem [DEPTH];
    logic [IMM_WIDTH-1:0]  r_imm_mem [DEPTH];
    logic [PC_WIDTH-1:0]   r_pc_mem  [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    state_t                r_state;
    state_t                w_state_nxt;

    assign w_grp    = bus.in_instr[31:28];
    assign w_op_lo  = bus.in_instr[3:0];
    assign w_op_mid = bus.in_instr[19:16];
    assign w_op_ls  = bus.in_instr[15:12];

    // Combinational decode of the incoming instruction by group
    always_comb begin
        w_dec = '0;
        w_imm = '0;
        case (w_grp)
            4'd0: begin
                w_dec.group        = w_grp;
                w_dec.ra           = bus.in_instr[27:24];
                w_dec.rb           = bus.in_instr[23:20];
                w_dec.rc           = bus.in_instr[19:16];
                w_dec.opcode       = w_op_lo;
                w_dec.causes_stall = (w_op_lo == c_g0_mul) || (w_op_lo == c_g0_udiv)
                                  || (w_op_lo == c_g0_sdiv);
            end
            4'd1: begin
                w_dec.group        = w_grp;
                w_dec.ra           = bus.in_instr[27:24];
                w_dec.rb           = bus.in_instr[23:20];
                w_dec.opcode       = w_op_mid;
                w_dec.imm_val      = bus.in_instr[15:0];
                w_imm              = IMM_WIDTH'($signed(bus.in_instr[15:0]));
                w_dec.causes_stall = (w_op_mid == c_g1_muli);
            end
            4'd2: begin
                w_dec.group          = w_grp;
                w_dec.ra             = bus.in_instr[27:24];
                w_dec.rb             = bus.in_instr[23:20];
                w_dec.opcode         = w_op_mid;
                w_dec.condition_type = w_op_mid;
                w_dec.imm_val        = bus.in_instr[15:0];
                w_imm                = IMM_WIDTH'($signed(bus.in_instr[15:0]));
                w_dec.causes_stall   = (w_op_mid < c_g2_bad2);
            end
            4'd3, 4'd4: begin
                w_dec.group          = w_grp;
                w_dec.ra             = bus.in_instr[27:24];
                w_dec.rb             = bus.in_instr[23:20];
                w_dec.rc             = bus.in_instr[19:16];
                w_dec.opcode         = w_op_lo;
                w_dec.condition_type = w_op_lo;
                w_dec.causes_stall   = (w_op_lo < c_g3_bad0);
            end
            4'd5: begin
                w_dec.group        = w_grp;
                w_dec.ra           = bus.in_instr[27:24];
                w_dec.rb           = bus.in_instr[23:20];
                w_dec.rc           = bus.in_instr[19:16];
                w_dec.opcode       = w_op_ls;
                w_dec.ldst_type    = w_op_ls[2:0];
                w_dec.imm_val      = 16'($signed(bus.in_instr[11:0]));
                w_imm              = IMM_WIDTH'($signed(bus.in_instr[11:0]));
                w_dec.causes_stall = 1'b1;
            end
            4'd6: begin
                w_dec.group        = w_grp;
                w_dec.ra           = bus.in_instr[27:24];
                w_dec.rb           = bus.in_instr[23:20];
                w_dec.opcode       = w_op_lo;
                w_dec.causes_stall = (w_op_lo == c_g6_cpy_ireta) || (w_op_lo == c_g6_cpy_idsta)
                                  || (w_op_lo == c_g6_reti) || (w_op_lo == c_g6_ei)
                                  || (w_op_lo == c_g6_di);
            end
            default: begin
                // Unknown group: all-zero record, i.e. add zero,zero,zero
                w_dec = '0;
            end
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_illegal = 1'b0;
        case (w_grp)
            4'd0:       w_bad = (w_op_lo  >= c_g0_bad0);
            4'd1:       w_bad = (w_op_mid >= c_g1_bad0);
            4'd2:       w_bad = (w_op_mid >= c_g2_bad2);
            4'd3, 4'd4: w_bad = (w_op_lo  >= c_g3_bad0);
            4'd5:       w_bad = (w_op_ls  >= c_g5_bad0);
            4'd6:       w_bad = (w_op_lo  >= c_g6_bad0);
            default:    w_bad = 1'b1;
        endcase
        // Illegal ops carry no fields but serialise so the trap handler runs alone
        if (w_bad) begin
            w_dec              = '0;
            w_imm              = '0;
            w_dec.causes_stall = 1'b1;
            w_illegal          = 1'b1;
        end
`endif
    end

    assign w_full         = (r_count == c_cnt_w'(DEPTH));
    assign w_empty        = (r_count == '0);
    assign bus.in_ready   = !w_full && !bus.flush && !reset;
    assign w_push         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = !w_empty && (r_state == ST_IDLE);
    assign w_pop          = bus.out_valid && bus.out_ready && !bus.flush;
    assign bus.interlocked = (r_state == ST_WAIT);
    assign bus.count      = r_count;

    // Head outputs read as zero whenever the queue is empty
    assign bus.out_dec = w_empty ? '0 : r_dec_mem[r_rd_ptr];
    assign bus.out_imm = w_empty ? '0 : r_imm_mem[r_rd_ptr];
    assign bus.out_pc  = w_empty ? '0 : r_pc_mem[r_rd_ptr];
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.out_illegal = w_empty ? 1'b0 : r_ill_mem[r_rd_ptr];
`endif

    // Entry storage: cleared on reset, written at the tail on push
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dec_mem[i] <= '0;
                r_imm_mem[i] <= '0;
                r_pc_mem[i]  <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                r_ill_mem[i] <= 1'b0;
`endif
            end
        end else if (w_push) begin
            r_dec_mem[r_wr_ptr] <= w_dec;
            r_imm_mem[r_wr_ptr] <= w_imm;
            r_pc_mem[r_wr_ptr]  <= bus.in_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_ill_mem[r_wr_ptr] <= w_illegal;
`endif
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Interlock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Interlock next state: a popped stalling head blocks issue until stall_done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop && r_dec_mem[r_rd_ptr].causes_stall) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.stall_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_decode_queue
// Description : Self-checking bench for instr_decode_queue (decode table plus
//               FIFO / interlock / flush / reset sequences, scoreboard checked).
//               Honours DECODE_ILLEGAL_TRAP_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_decode_queue;
    import PkgInstrDecoder::*;

    localparam int DEPTH     = 2;
    localparam int IMM_WIDTH = 16;
    localparam int PC_WIDTH  = 32;

    logic clk = 1'b0;
    logic reset;

    instr_decode_queue_if #(.DEPTH(DEPTH), .IMM_WIDTH(IMM_WIDTH), .PC_WIDTH(PC_WIDTH)) bus ();

    instr_decode_queue #(.DEPTH(DEPTH), .IMM_WIDTH(IMM_WIDTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        PortOut_InstrDecoder  dec;
        logic [IMM_WIDTH-1:0] imm;
        logic [PC_WIDTH-1:0]  pc;
        logic                 ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic PortOut_InstrDecoder mk(input logic [3:0] g, input logic [3:0] ra,
            input logic [3:0] rb, input logic [3:0] rc, input logic [3:0] op,
            input logic [15:0] imm, input logic [3:0] cond, input logic [2:0] ldst,
            input logic st);
        PortOut_InstrDecoder d;
        d.group = g; d.ra = ra; d.rb = rb; d.rc = rc; d.opcode = op;
        d.imm_val = imm; d.condition_type = cond; d.ldst_type = ldst; d.causes_stall = st;
        return d;
    endfunction

    function automatic exp_t mke(input PortOut_InstrDecoder d, input logic [15:0] imm,
            input logic [31:0] pc, input logic bad);
        exp_t e;
        e.dec = d; e.imm = imm; e.pc = pc; e.ill = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (bad) begin
            e.dec = mk(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 4'd0, 3'd0, 1'b1);
            e.imm = '0;
            e.ill = 1'b1;
        end
`else
        if (bad) begin
            e.ill = 1'b0;
        end
`endif
        return e;
    endfunction

    function automatic exp_t add_exp(input logic [3:0] ra, input logic [3:0] rb,
            input logic [3:0] rc, input logic [31:0] pc);
        return mke(mk(4'd0, ra, rb, rc, 4'd0, 16'h0, 4'd0, 3'd0, 1'b0), 16'h0, pc, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until accepted; scoreboard entry recorded on acceptance
    task automatic push(input logic [31:0] instr, input exp_t e);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = e.pc;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.in_ready) begin
                sb.push_back(e);
                tick();
                bus.in_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL push_timeout actual=not_accepted required=accepted");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) return;
            tick();
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout actual=%0d left required=0", sb.size());
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !bus.flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_pop actual=pc_%0h required=no_pop", bus.out_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_dec", 64'(bus.out_dec), 64'(e.dec));
                chk("pop_imm", 64'(bus.out_imm), 64'(e.imm));
                chk("pop_pc",  64'(bus.out_pc),  64'(e.pc));
`ifdef DECODE_ILLEGAL_TRAP_EN
                chk("pop_illegal", 64'(bus.out_illegal), 64'(e.ill));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[14];
    exp_t e_ld;
    int   accepted;

    initial begin
        vt[0]  = '{32'h0123_0000, mke(mk(0, 1, 2, 3, 0,  16'h0000, 0,  0, 0), 16'h0000, 32'h100, 0)};
        vt[1]  = '{32'h0456_0004, mke(mk(0, 4, 5, 6, 4,  16'h0000, 0,  0, 1), 16'h0000, 32'h104, 0)};
        vt[2]  = '{32'h1780_8001, mke(mk(1, 7, 8, 0, 0,  16'h8001, 0,  0, 0), 16'h8001, 32'h108, 0)};
        vt[3]  = '{32'h1124_0010, mke(mk(1, 1, 2, 0, 4,  16'h0010, 0,  0, 1), 16'h0010, 32'h10C, 0)};
        vt[4]  = '{32'h2342_FFFE, mke(mk(2, 3, 4, 0, 2,  16'hFFFE, 2,  0, 1), 16'hFFFE, 32'h110, 0)};
        vt[5]  = '{32'h200E_0000, mke(mk(2, 0, 0, 0, 14, 16'h0000, 14, 0, 0), 16'h0000, 32'h114, 1)};
        vt[6]  = '{32'h3123_0001, mke(mk(3, 1, 2, 3, 1,  16'h0000, 1,  0, 1), 16'h0000, 32'h118, 0)};
        vt[7]  = '{32'h4567_0000, mke(mk(4, 5, 6, 7, 0,  16'h0000, 0,  0, 1), 16'h0000, 32'h11C, 0)};
        vt[8]  = '{32'h5123_2FFF, mke(mk(5, 1, 2, 3, 2,  16'hFFFF, 0,  2, 1), 16'hFFFF, 32'h120, 0)};
        vt[9]  = '{32'h5456_57FF, mke(mk(5, 4, 5, 6, 5,  16'h07FF, 0,  5, 1), 16'h07FF, 32'h124, 0)};
        vt[10] = '{32'h69A0_0000, mke(mk(6, 9, 10, 0, 0, 16'h0000, 0,  0, 0), 16'h0000, 32'h128, 0)};
        vt[11] = '{32'h6000_0005, mke(mk(6, 0, 0, 0, 5,  16'h0000, 0,  0, 1), 16'h0000, 32'h12C, 0)};
        vt[12] = '{32'hF123_4567, mke(mk(0, 0, 0, 0, 0,  16'h0000, 0,  0, 0), 16'h0000, 32'h130, 1)};
        vt[13] = '{32'h0000_000F, mke(mk(0, 0, 0, 0, 15, 16'h0000, 0,  0, 0), 16'h0000, 32'h134, 1)};

        // Reset held two cycles with fetch presenting an instruction
        reset = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h0123_0000;
        bus.in_pc = '0; bus.out_ready = 1'b0; bus.stall_done = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_out_dec", 64'(bus.out_dec), 0);
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 1);

        // Decode table, one instruction at a time
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = vt[i].instr; bus.in_pc = vt[i].e.pc;
            #1;
            chk("no_comb_path", 64'(bus.out_valid), 0);
            push(vt[i].instr, vt[i].e);
            chk("latency_valid", 64'(bus.out_valid), 1);
            wait_drain();
            if (vt[i].e.dec.causes_stall) begin
                chk("stall_interlocked", 64'(bus.interlocked), 1);
                bus.stall_done = 1'b1; tick(); bus.stall_done = 1'b0;
                chk("stall_release", 64'(bus.interlocked), 0);
            end else begin
                chk("no_interlock", 64'(bus.interlocked), 0);
            end
        end

        // Fill to full with three offered instructions, then drain in order
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = {4'h0, 4'(k + 1), 4'(k + 2), 4'(k + 3), 16'h0};
            bus.in_pc    = 32'h200 + 32'(4 * k);
            #1;
            if (bus.in_ready) begin
                sb.push_back(add_exp(4'(k + 1), 4'(k + 2), 4'(k + 3), 32'h200 + 32'(4 * k)));
                accepted++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_accepted", 64'(accepted), 2);
        chk("full_count", 64'(bus.count), 2);
        chk("full_in_ready", 64'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        #1;
        chk("full_pop_no_accept", 64'(bus.in_ready), 0);
        tick();
        chk("drain_count1", 64'(bus.count), 1);
        push({4'h0, 4'd9, 4'd10, 4'd11, 16'h0}, add_exp(4'd9, 4'd10, 4'd11, 32'h300));
        chk("pushpop_count", 64'(bus.count), 1);
        tick();
        chk("drain_count0", 64'(bus.count), 0);
        wait_drain();

        // Stalling load followed by an add: add waits for stall_done
        bus.out_ready = 1'b0;
        e_ld = mke(mk(5, 1, 2, 3, 2, 16'hFFFF, 0, 2, 1), 16'hFFFF, 32'h400, 0);
        push(32'h5123_2FFF, e_ld);
        push(32'h0123_0000, add_exp(4'd1, 4'd2, 4'd3, 32'h404));
        bus.out_ready = 1'b1;
        tick();
        chk("ld_interlocked", 64'(bus.interlocked), 1);
        chk("ld_out_valid", 64'(bus.out_valid), 0);
        chk("ld_count", 64'(bus.count), 1);
        tick(); tick(); tick();
        chk("ld_hold_valid", 64'(bus.out_valid), 0);
        bus.stall_done = 1'b1; tick(); bus.stall_done = 1'b0;
        chk("ld_release", 64'(bus.interlocked), 0);
        chk("ld_next_valid", 64'(bus.out_valid), 1);
        tick();
        chk("ld_drained", 64'(bus.count), 0);
        wait_drain();

        // stall_done while idle is ignored; stall_done coinciding with a stalling pop loses
        bus.stall_done = 1'b1; tick(); bus.stall_done = 1'b0;
        chk("idle_done_ignored", 64'(bus.interlocked), 0);
        push(32'h0456_0004, mke(mk(0, 4, 5, 6, 4, 16'h0, 0, 0, 1), 16'h0, 32'h500, 0));
        bus.stall_done = 1'b1; tick(); bus.stall_done = 1'b0;
        chk("wait_wins", 64'(bus.interlocked), 1);
        bus.stall_done = 1'b1; tick(); bus.stall_done = 1'b0;
        chk("wait_release", 64'(bus.interlocked), 0);

        // Flush with two queued entries while interlocked
        push(32'h5123_2FFF, mke(mk(5, 1, 2, 3, 2, 16'hFFFF, 0, 2, 1), 16'hFFFF, 32'h600, 0));
        tick();
        bus.out_ready = 1'b0;
        push(32'h0123_0000, add_exp(4'd1, 4'd2, 4'd3, 32'h604));
        push(32'h0456_0000, add_exp(4'd4, 4'd5, 4'd6, 32'h608));
        chk("pre_flush_count", 64'(bus.count), 2);
        chk("pre_flush_intlk", 64'(bus.interlocked), 1);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h0789_0000; bus.in_pc = 32'h60C;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 0);
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        sb.delete();
        chk("flush_count", 64'(bus.count), 0);
        chk("flush_intlk", 64'(bus.interlocked), 0);
        chk("flush_out_valid", 64'(bus.out_valid), 0);
        chk("flush_out_pc", 64'(bus.out_pc), 0);

        // Reset in the middle of operation
        push(32'h0123_0000, add_exp(4'd1, 4'd2, 4'd3, 32'h900));
        chk("midrst_pre_count", 64'(bus.count), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        sb.delete();
        chk("midrst_count", 64'(bus.count), 0);
        chk("midrst_out_valid", 64'(bus.out_valid), 0);
        chk("midrst_out_pc", 64'(bus.out_pc), 0);
        tick();
        chk("midrst_in_ready", 64'(bus.in_ready), 1);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
